// File: rtl/cnn_pkg.sv
// rtl/cnn_pkg.sv - shared constants and FSM state type for the CNN sequencer
package cnn_pkg;

    localparam int IX      = 28;
    localparam int IY      = 28;
    localparam int I_F_BW  = 8;
    localparam int N_IMG   = 16;
    localparam int N_CLASS = 26;

    localparam logic [7:0] ASCII_A   = 8'h41;
    localparam logic [7:0] ASCII_UNK = 8'h3F;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        DRAIN,
        WAIT,
        DONE
    } seq_state_t;

endpackage

// File: rtl/cnn_class2ascii.sv
// rtl/cnn_class2ascii.sv - combinational class index to ASCII letter mapping
module cnn_class2ascii #(
    parameter int N_CLASS  = cnn_pkg::N_CLASS,
    parameter int CLASS_BW = 5
) (
    input  logic [CLASS_BW-1:0] i_class,
    output logic [7:0]          o_alpha
);
    import cnn_pkg::*;

    logic w_valid;

    // classes beyond the trained range map to '?'
    assign w_valid = 32'(i_class) < $unsigned(N_CLASS);
    assign o_alpha = w_valid ? (ASCII_A + 8'(i_class)) : ASCII_UNK;

endmodule

// File: rtl/cnn_seq_ctrl.sv
// rtl/cnn_seq_ctrl.sv - image ROM streamer and CNN result sequencer (optional watchdog: SEQ_TIMEOUT_EN)
module cnn_seq_ctrl #(
    parameter int IX          = cnn_pkg::IX,
    parameter int IY          = cnn_pkg::IY,
    parameter int I_F_BW      = cnn_pkg::I_F_BW,
    parameter int N_IMG       = cnn_pkg::N_IMG,
    parameter int N_CLASS     = cnn_pkg::N_CLASS,
    parameter int CLASS_BW    = 5,
    parameter int TIMEOUT_CYC = 4096
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic                              i_start,
    input  logic [3:0]                        i_sw,
    output logic                              o_busy,
    output logic                              o_rom_en,
    output logic [$clog2(N_IMG*IX*IY)-1:0]    o_rom_addr,
    input  logic [I_F_BW-1:0]                 i_rom_data,
    output logic                              o_pix_valid,
    output logic [I_F_BW-1:0]                 o_pixel,
    input  logic                              i_core_done,
    input  logic [CLASS_BW-1:0]               i_core_class,
    output logic                              o_out_valid,
    output logic [7:0]                        o_alpha,
    output logic                              o_timeout
);
    import cnn_pkg::*;

    localparam int NPIX    = IX * IY;
    localparam int ADDR_BW = $clog2(N_IMG * IX * IY);
    localparam int PIX_BW  = (NPIX > 1) ? $clog2(NPIX) : 1;

    seq_state_t          r_state;
    seq_state_t          w_next;
    logic [PIX_BW-1:0]   r_pix_idx;
    logic [3:0]          r_sel;
    logic [CLASS_BW-1:0] r_class;
    logic                r_to;
    logic                r_have;
    logic                r_pix_valid;
    logic [I_F_BW-1:0]   r_pixel;
    logic                w_fetch_last;
    logic                w_core_hit;
    logic                w_timeout;
    logic [7:0]          w_class_ascii;

    assign w_fetch_last = (r_pix_idx == PIX_BW'(NPIX - 1));
    assign w_core_hit   = (r_state == WAIT) && i_core_done;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_BW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    logic [CNT_BW-1:0] r_wait_cnt;

    // watchdog: cleared while draining so it starts at zero on WAIT entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wait_cnt <= '0;
        end else if (r_state == DRAIN) begin
            r_wait_cnt <= '0;
        end else if (r_state == WAIT) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end
    end

    // a core result in the last WAIT cycle wins over the watchdog
    assign w_timeout = (r_state == WAIT) && !i_core_done &&
                       (r_wait_cnt == CNT_BW'(TIMEOUT_CYC - 1));
    assign o_timeout = (r_state == DONE) && r_to;
`else
    assign w_timeout = 1'b0;
    assign o_timeout = 1'b0;
`endif

    // state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // next-state and state-decoded outputs
    always_comb begin
        w_next      = r_state;
        o_busy      = 1'b1;
        o_rom_en    = 1'b0;
        o_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_start) begin
                    w_next = FETCH;
                end
            end
            FETCH: begin
                o_rom_en = 1'b1;
                if (w_fetch_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                w_next = WAIT;
            end
            WAIT: begin
                if (w_core_hit || w_timeout) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                o_out_valid = 1'b1;
                w_next      = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // image select, pixel counter, pixel pipeline and result latches
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sel       <= '0;
            r_pix_idx   <= '0;
            r_class     <= '0;
            r_to        <= 1'b0;
            r_have      <= 1'b0;
            r_pix_valid <= 1'b0;
            r_pixel     <= '0;
        end else begin
            r_pix_valid <= o_rom_en;
            if (o_rom_en) begin
                r_pixel <= i_rom_data;
            end
            if ((r_state == IDLE) && i_start) begin
                r_sel     <= i_sw;
                r_pix_idx <= '0;
            end else if (r_state == FETCH) begin
                r_pix_idx <= w_fetch_last ? '0 : r_pix_idx + 1'b1;
            end
            if (w_core_hit) begin
                r_class <= i_core_class;
                r_to    <= 1'b0;
                r_have  <= 1'b1;
            end else if (w_timeout) begin
                r_to    <= 1'b1;
                r_have  <= 1'b1;
            end
        end
    end

    cnn_class2ascii #(
        .N_CLASS  (N_CLASS),
        .CLASS_BW (CLASS_BW)
    ) u_class2ascii (
        .i_class (r_class),
        .o_alpha (w_class_ascii)
    );

    assign o_rom_addr  = o_rom_en ? (ADDR_BW'(r_sel) * ADDR_BW'(NPIX) + ADDR_BW'(r_pix_idx)) : '0;
    assign o_pix_valid = r_pix_valid;
    assign o_pixel     = r_pixel;
    assign o_alpha     = !r_have ? 8'h00 : (r_to ? ASCII_UNK : w_class_ascii);

endmodule

// File: tb/tb_cnn_seq_ctrl.sv
// tb/tb_cnn_seq_ctrl.sv - directed self-checking bench for cnn_seq_ctrl
module tb_cnn_seq_ctrl;

    localparam int NPIX = 784;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        i_start = 1'b0;
    logic [3:0]  i_sw = 4'd0;
    logic        o_busy;
    logic        o_rom_en;
    logic [13:0] o_rom_addr;
    logic [7:0]  i_rom_data;
    logic        o_pix_valid;
    logic [7:0]  o_pixel;
    logic        i_core_done = 1'b0;
    logic [4:0]  i_core_class = 5'd0;
    logic        o_out_valid;
    logic [7:0]  o_alpha;
    logic        o_timeout;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input logic [13:0] a);
        return a[7:0] ^ {2'b00, a[13:8]} ^ 8'h5A;
    endfunction

    assign i_rom_data = rom_f(o_rom_addr);

    cnn_seq_ctrl #(
        .IX(28), .IY(28), .I_F_BW(8), .N_IMG(16), .N_CLASS(26),
        .CLASS_BW(5), .TIMEOUT_CYC(4096)
    ) dut (
        .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_sw(i_sw),
        .o_busy(o_busy), .o_rom_en(o_rom_en), .o_rom_addr(o_rom_addr),
        .i_rom_data(i_rom_data), .o_pix_valid(o_pix_valid), .o_pixel(o_pixel),
        .i_core_done(i_core_done), .i_core_class(i_core_class),
        .o_out_valid(o_out_valid), .o_alpha(o_alpha), .o_timeout(o_timeout)
    );

    task automatic do_frame(input logic [3:0] sw, output bit ok);
        i_sw = sw;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_sw = 4'd0;
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            if (o_busy && !o_rom_en && !o_pix_valid) ok = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        i_start = 1'b1;
        i_core_done = 1'b1;
        i_sw = 4'hF;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_busy, o_rom_en, o_pix_valid, o_out_valid, o_timeout} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags: got %b expected 00000", {o_busy, o_rom_en, o_pix_valid, o_out_valid, o_timeout});
        end
        checks++;
        if (o_rom_addr !== 14'd0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", o_rom_addr); end
        checks++;
        if (o_pixel !== 8'd0) begin failures++; $display("FAIL reset_pixel: got %0h expected 0", o_pixel); end
        checks++;
        if (o_alpha !== 8'd0) begin failures++; $display("FAIL reset_alpha: got %0h expected 0", o_alpha); end
        i_start = 1'b0;
        i_core_done = 1'b0;
        i_sw = 4'd0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL reset_idle: busy got %b expected 0", o_busy); end
    endtask

    task automatic test_fetch;
        int n_en, n_pv, first_cyc, addr_err, pix_err;
        logic [13:0] first_addr, last_addr;
        bit done;
        n_en = 0; n_pv = 0; first_cyc = -1; addr_err = 0; pix_err = 0; done = 1'b0;
        first_addr = '0; last_addr = '0;
        i_sw = 4'd9;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_sw = 4'd0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (o_rom_en) begin
                if (n_en == 0) begin first_cyc = cyc; first_addr = o_rom_addr; end
                if (o_rom_addr !== 14'(7056 + n_en)) addr_err++;
                last_addr = o_rom_addr;
                n_en++;
            end
            if (o_pix_valid) begin
                if (o_pixel !== rom_f(14'(7056 + n_pv))) pix_err++;
                n_pv++;
            end
            if (o_busy && !o_rom_en && !o_pix_valid && n_pv > 0) done = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (first_cyc !== 0) begin failures++; $display("FAIL fetch_latency: got %0d expected 0", first_cyc); end
        checks++;
        if (first_addr !== 14'd7056) begin failures++; $display("FAIL fetch_first_addr: got %0d expected 7056", first_addr); end
        checks++;
        if (last_addr !== 14'd7839) begin failures++; $display("FAIL fetch_last_addr: got %0d expected 7839", last_addr); end
        checks++;
        if (n_en !== NPIX) begin failures++; $display("FAIL fetch_en_count: got %0d expected %0d", n_en, NPIX); end
        checks++;
        if (n_pv !== NPIX) begin failures++; $display("FAIL fetch_strobes: got %0d expected %0d", n_pv, NPIX); end
        checks++;
        if (addr_err !== 0) begin failures++; $display("FAIL fetch_addr_seq: got %0d errors expected 0", addr_err); end
        checks++;
        if (pix_err !== 0) begin failures++; $display("FAIL fetch_pixels: got %0d errors expected 0", pix_err); end
        checks++;
        if (done !== 1'b1) begin failures++; $display("FAIL fetch_reach_wait: got %b expected 1", done); end
        i_core_done = 1'b1;
        i_core_class = 5'd0;
        @(negedge clk);
        i_core_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_class;
        bit ok;
        do_frame(4'd2, ok);
        checks++;
        if (ok !== 1'b1) begin failures++; $display("FAIL class_reach_wait: got %b expected 1", ok); end
        i_core_done = 1'b1;
        i_core_class = 5'd2;
        @(negedge clk);
        i_core_done = 1'b0;
        i_core_class = 5'd0;
        checks++;
        if (o_out_valid !== 1'b1) begin failures++; $display("FAIL class_out_valid: got %b expected 1", o_out_valid); end
        checks++;
        if (o_alpha !== 8'h43) begin failures++; $display("FAIL class_alpha: got %0h expected 43", o_alpha); end
        checks++;
        if (o_timeout !== 1'b0) begin failures++; $display("FAIL class_timeout: got %b expected 0", o_timeout); end
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if ({o_out_valid, o_busy} !== 2'b00) begin failures++; $display("FAIL done_start_ignored: got %b expected 00", {o_out_valid, o_busy}); end
        checks++;
        if (o_alpha !== 8'h43) begin failures++; $display("FAIL class_alpha_hold: got %0h expected 43", o_alpha); end
        @(negedge clk);
    endtask

    task automatic test_boundary;
        logic [4:0] cls [3];
        logic [7:0] exp_a [3];
        bit ok;
        cls[0] = 5'd25; exp_a[0] = 8'h5A;
        cls[1] = 5'd26; exp_a[1] = 8'h3F;
        cls[2] = 5'd0;  exp_a[2] = 8'h41;
        for (int i = 0; i < 3; i++) begin
            do_frame(4'(i + 1), ok);
            i_core_done = 1'b1;
            i_core_class = cls[i];
            @(negedge clk);
            i_core_done = 1'b0;
            checks++;
            if (!ok || o_out_valid !== 1'b1 || o_alpha !== exp_a[i]) begin
                failures++;
                $display("FAIL boundary_class_%0d: got ok=%b valid=%b alpha=%0h expected ok=1 valid=1 alpha=%0h", cls[i], ok, o_out_valid, o_alpha, exp_a[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_ignore;
        int n_en, n_pv, addr_err, ov_seen;
        bit done;
        n_en = 0; n_pv = 0; addr_err = 0; ov_seen = 0; done = 1'b0;
        i_sw = 4'd3;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_sw = 4'd0;
        for (int cyc = 0; cyc < 1000 && !done; cyc++) begin
            if (o_out_valid) ov_seen++;
            if (o_rom_en) begin
                if (o_rom_addr !== 14'(3 * NPIX + n_en)) addr_err++;
                n_en++;
            end
            if (o_pix_valid) n_pv++;
            i_start = 1'b0;
            i_core_done = 1'b0;
            if (cyc == 10) begin
                i_start = 1'b1;
                i_sw = 4'd5;
                i_core_done = 1'b1;
                i_core_class = 5'd1;
            end
            if (!o_rom_en && o_pix_valid) begin
                i_core_done = 1'b1;
                i_core_class = 5'd4;
            end
            if (o_busy && !o_rom_en && !o_pix_valid && n_pv > 0) done = 1'b1;
            else @(negedge clk);
        end
        i_sw = 4'd0;
        checks++;
        if (addr_err !== 0 || n_en !== NPIX) begin failures++; $display("FAIL ignore_addr_seq: got errors=%0d count=%0d expected 0 and %0d", addr_err, n_en, NPIX); end
        checks++;
        if (ov_seen !== 0 || done !== 1'b1) begin failures++; $display("FAIL ignore_early_done: got out_valid=%0d done=%b expected 0 and 1", ov_seen, done); end
        i_core_done = 1'b1;
        i_core_class = 5'd30;
        @(negedge clk);
        i_core_done = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_alpha !== 8'h3F) begin failures++; $display("FAIL class30_alpha: got valid=%b alpha=%0h expected 1 and 3f", o_out_valid, o_alpha); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int n_pv, ov_cnt, busy_cnt;
        bit ok;
        n_pv = 0; ov_cnt = 0; busy_cnt = 0;
        i_sw = 4'd7;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        i_sw = 4'd0;
        for (int cyc = 0; cyc < 1000 && n_pv < 400; cyc++) begin
            if (o_pix_valid) n_pv++;
            if (n_pv < 400) @(negedge clk);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({o_busy, o_rom_en, o_pix_valid, o_out_valid, o_timeout} !== 5'b0 || o_rom_addr !== 14'd0 ||
            o_pixel !== 8'd0 || o_alpha !== 8'd0) begin
            failures++;
            $display("FAIL midreset_outputs: got flags=%b addr=%0d pix=%0h alpha=%0h expected all 0",
                     {o_busy, o_rom_en, o_pix_valid, o_out_valid, o_timeout}, o_rom_addr, o_pixel, o_alpha);
        end
        @(negedge clk);
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 900; cyc++) begin
            @(negedge clk);
            i_core_done = (cyc == 3);
            if (o_out_valid) ov_cnt++;
            if (o_busy) busy_cnt++;
        end
        i_core_done = 1'b0;
        checks++;
        if (ov_cnt !== 0 || busy_cnt !== 0) begin failures++; $display("FAIL midreset_abort: got out_valid=%0d busy=%0d expected 0 and 0", ov_cnt, busy_cnt); end
        i_sw = 4'd0;
        i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
        checks++;
        if (o_rom_en !== 1'b1 || o_rom_addr !== 14'd0) begin failures++; $display("FAIL restart_addr: got en=%b addr=%0d expected 1 and 0", o_rom_en, o_rom_addr); end
        ok = 1'b0;
        for (int n = 0; n < 1000 && !ok; n++) begin
            if (o_busy && !o_rom_en && !o_pix_valid) ok = 1'b1;
            else @(negedge clk);
        end
        i_core_done = 1'b1;
        @(negedge clk);
        i_core_done = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_wait_timeout;
        bit ok;
        int n;
        bit seen;
`ifdef SEQ_TIMEOUT_EN
        do_frame(4'd1, ok);
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 5000 && !seen; c++) begin
            if (o_out_valid) seen = 1'b1;
            else begin @(negedge clk); n++; end
        end
        checks++;
        if (!ok || n !== 4096) begin failures++; $display("FAIL timeout_latency: got %0d expected 4096", n); end
        checks++;
        if (o_timeout !== 1'b1 || o_alpha !== 8'h3F) begin failures++; $display("FAIL timeout_flags: got to=%b alpha=%0h expected 1 and 3f", o_timeout, o_alpha); end
        @(negedge clk);
        do_frame(4'd2, ok);
        repeat (4095) @(negedge clk);
        i_core_done = 1'b1;
        i_core_class = 5'd2;
        @(negedge clk);
        i_core_done = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_timeout !== 1'b0 || o_alpha !== 8'h43) begin
            failures++;
            $display("FAIL timeout_priority: got valid=%b to=%b alpha=%0h expected 1 0 43", o_out_valid, o_timeout, o_alpha);
        end
        @(negedge clk);
`else
        do_frame(4'd1, ok);
        n = 0;
        seen = 1'b0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (o_out_valid) seen = 1'b1;
            if (o_busy) n++;
        end
        checks++;
        if (!ok || seen !== 1'b0 || n !== 300) begin failures++; $display("FAIL wait_forever: got out_valid=%b busy_cycles=%0d expected 0 and 300", seen, n); end
        i_core_done = 1'b1;
        i_core_class = 5'd1;
        @(negedge clk);
        i_core_done = 1'b0;
        checks++;
        if (o_out_valid !== 1'b1 || o_alpha !== 8'h42 || o_timeout !== 1'b0) begin
            failures++;
            $display("FAIL wait_release: got valid=%b alpha=%0h to=%b expected 1 42 0", o_out_valid, o_alpha, o_timeout);
        end
        @(negedge clk);
`endif
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_class();
        test_boundary();
        test_ignore();
        test_reset_mid();
        test_wait_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
